// File: rtl/counter_sched.sv
// Round-robin owner of one shared 5-bit loadable counter; loads the owner's start value and pulses done on 5'h1F.
// Optional feature: define COUNTER_SCHED_ABORT_EN to let an owner cancel its interval by dropping req.
module counter_sched #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [5*NREQ-1:0]    start_val,
  input  logic [4:0]           cnt_value,
  output logic                 cnt_load,
  output logic [4:0]           cnt_data,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] last;

  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W:0]   idx;
  logic [4:0]       win_start;
  logic [NREQ-1:0]  win_oh;
  logic             abort;

  // Circular search starting just after the previous owner; one extra bit absorbs the wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = {1'b0, last} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NREQ))
        idx = idx - (PTR_W+1)'(NREQ);
      if (!found && req[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    win_start = '0;
    win_oh    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PTR_W'(i)) begin
        win_start = start_val[5*i +: 5];
        win_oh[i] = 1'b1;
      end
    end
  end

`ifdef COUNTER_SCHED_ABORT_EN
  assign abort = ~req[owner];
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      owner    <= '0;
      last     <= PTR_W'(NREQ-1);
      cnt_load <= 1'b0;
      cnt_data <= 5'h00;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            owner    <= win;
            last     <= win;
            cnt_data <= win_start;
            cnt_load <= 1'b1;
            grant    <= win_oh;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_load <= 1'b0;
          if (abort) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // A cancelled interval never reports done, even on the roll-over cycle.
          if (abort) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt_value == 5'h1F) begin
            done        <= '0;
            done[owner] <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          grant <= '0;
          done  <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed phases plus random requesters, checked by an event scoreboard.
module tb_counter_sched;
  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] start_val;
  logic [4:0]  cnt_value;
  logic        cnt_load;
  logic [4:0]  cnt_data;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;

  always #5 clk = ~clk;

  counter_sched #(.NREQ(NREQ), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .start_val(start_val), .cnt_value(cnt_value),
    .cnt_load(cnt_load), .cnt_data(cnt_data), .grant(grant), .done(done), .busy(busy)
  );

  // The shared counter: loads on strobe, otherwise free-runs and wraps.
  logic [4:0] cnt = 5'h00;
  assign cnt_value = cnt;
  always @(posedge clk) begin
    if (cnt_load === 1'b1) cnt <= cnt_data;
    else                   cnt <= cnt + 5'd1;
  end

  typedef struct {
    int         cyc;
    int         kind;   // 0 grant, 1 load, 2 done, 3 grant release
    logic [3:0] vec;
    logic [4:0] dat;
  } ev_t;

  ev_t  q[$];
  int   gorder[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic exp_busy = 1'b0;

  logic [3:0] mask = 4'h0;
  logic [3:0] cool = 4'h0;
  int         prob = 0;
  bit         oneshot = 1'b0;
  bit         rand_start = 1'b0;

  function automatic void push(int c, int k, logic [3:0] v, logic [4:0] d);
    ev_t e;
    e.cyc = c; e.kind = k; e.vec = v; e.dat = d;
    q.push_back(e);
  endfunction

  task automatic chk(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_ev(int kind, logic [3:0] vec, logic [4:0] dat);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL ev_unexpected cyc=%0d got kind=%0d vec=%b dat=%h want nothing", cyc, kind, vec, dat);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.vec !== vec || e.dat !== dat) begin
        bad++;
        $display("FAIL ev_match got kind=%0d cyc=%0d vec=%b dat=%h want kind=%0d cyc=%0d vec=%b dat=%h",
                 kind, cyc, vec, dat, e.kind, e.cyc, e.vec, e.dat);
      end
    end
  endtask

  // Reference model: whole-interval arithmetic, one grant decision per idle edge.
  initial begin : model
    int   m_last, e0, s, own, idx;
    bit   act, fnd;
    logic [3:0] oh;
    m_last = NREQ - 1; e0 = 0; s = 0; own = 0; act = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        if (act) begin
          q.delete();
          push(cyc, 3, 4'b0, 5'h0);
        end
        act = 1'b0; m_last = NREQ - 1; exp_busy = 1'b0;
      end else if (act) begin
`ifdef COUNTER_SCHED_ABORT_EN
        if (cyc >= e0 + 1 && cyc <= e0 + 1 + (32 - s) && !req[own]) begin
          q.delete();
          push(cyc, 3, 4'b0, 5'h0);
          act = 1'b0; exp_busy = 1'b0;
        end else
`endif
        if (cyc == e0 + 34 - s) begin
          act = 1'b0; exp_busy = 1'b0;
        end
      end else if (req != 4'b0) begin
        fnd = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (!fnd && req[idx]) begin fnd = 1'b1; own = idx; end
        end
        s = int'(start_val[5*own +: 5]);
        oh = 4'b0001 << own;
        e0 = cyc; m_last = own; act = 1'b1; exp_busy = 1'b1;
        push(e0, 0, oh, 5'h0);
        push(e0, 1, 4'b0, 5'(s));
        push(e0 + 1 + (32 - s), 2, oh, 5'h0);
        push(e0 + 34 - s, 3, 4'b0, 5'h0);
      end
    end
  end

  // Monitor: turns DUT output activity into events and matches them against the queue.
  initial begin : monitor
    logic [3:0] pg;
    logic [4:0] pc;
    pg = 4'b0; pc = 5'h0;
    forever begin
      @(negedge clk);
      if (grant !== pg && grant !== 4'b0) begin
        check_ev(0, grant, 5'h0);
        for (int i = 0; i < NREQ; i++) if (grant[i]) gorder.push_back(i);
      end
      if (grant === 4'b0 && pg !== 4'b0) check_ev(3, 4'b0, 5'h0);
      if (cnt_load === 1'b1) check_ev(1, 4'b0, cnt_data);
      if (done !== 4'b0) begin
        check_ev(2, done, 5'h0);
        chk("done_after_1f", int'(pc), 31);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL ev_missing kind=%0d due cyc=%0d not seen by cyc=%0d", q[0].kind, q[0].cyc, cyc);
        void'(q.pop_front());
      end
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
      end
      pg = grant; pc = cnt_value;
    end
  end

  function automatic logic [4:0] pick();
    case ($urandom_range(5))
      0:       return 5'h1F;
      1:       return 5'h1E;
      2:       return 5'h1C;
      3:       return 5'h10;
      4:       return 5'h00;
      default: return 5'($urandom_range(31));
    endcase
  endfunction

  // One clock of stimulus; requesters drop on done and wait one cycle before re-requesting.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && done[i]) begin
        req[i] = 1'b0; cool[i] = 1'b1;
        if (oneshot) mask[i] = 1'b0;
      end else if (cool[i]) begin
        cool[i] = 1'b0;
      end else if (!req[i] && mask[i] && $urandom_range(99) < prob) begin
        req[i] = 1'b1;
      end
      if (rand_start && $urandom_range(3) == 0) start_val[5*i +: 5] = pick();
    end
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while ((req != 4'b0 || busy) && n < 500) begin step(); n++; end
    chk(name, int'(n < 500), 1);
  endtask

  task automatic run_one(input int i, input logic [4:0] s, output int nbusy, output int nrun);
    int n, tg, td;
    n = 0; tg = -1; td = -1; nbusy = 0;
    start_val[5*i +: 5] = s; mask[i] = 1'b1; oneshot = 1'b1; prob = 100;
    while (n < 100 && !(td >= 0 && !busy)) begin
      step(); n++;
      if (busy) nbusy++;
      if (grant[i] && tg < 0) tg = n;
      if (done[i] && td < 0) td = n;
    end
    chk("tmo_run_one", int'(n < 100), 1);
    nrun = td - tg - 1;
  endtask

  initial begin : stim
    int b, r, n;
    rst = 1'b1; req = 4'b1111; start_val = {4{5'h1F}};

    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_outputs", int'({grant, done, cnt_load, cnt_data, busy}), 0);
    end
    rst = 1'b0; mask = 4'hF; prob = 100; oneshot = 1'b0;
    n = 0;
    while (gorder.size() < 5 && n < 300) begin step(); n++; end
    chk("tmo_fair", int'(n < 300), 1);
    for (int j = 0; j < 5; j++)
      chk("rr_order", (gorder.size() > j) ? gorder[j] : -1, j % 4);
    mask = 4'h0;
    drain("tmo_drain_fair");

    run_one(2, 5'h1C, b, r);
    chk("single_busy", b, 6);
    chk("single_run", r, 4);
    run_one(3, 5'h1F, b, r);
    chk("min_run", r, 1);
    chk("min_busy", b, 3);
    run_one(0, 5'h00, b, r);
    chk("max_run", r, 32);
    chk("max_busy", b, 34);

    // Reset during the 10th RUN cycle.
    mask = 4'h0; start_val[5 +: 5] = 5'h00; req[1] = 1'b1;
    n = 0;
    while (!grant[1] && n < 20) begin step(); n++; end
    chk("tmo_grant1", int'(n < 20), 1);
    repeat (10) step();
    rst = 1'b1; req = 4'b0;
    step();
    chk("midrst_clear", int'({grant, done, busy}), 0);
    step();
    rst = 1'b0; req = 4'b1001;
    n = 0;
    while (grant == 4'b0 && n < 20) begin step(); n++; end
    chk("post_rst_prio", int'(grant), 1);
    drain("tmo_drain_rst");

    // Owner drops req mid-run while another requester waits.
    start_val[5 +: 5] = 5'h00; req[1] = 1'b1;
    n = 0;
    while (!grant[1] && n < 20) begin step(); n++; end
    chk("tmo_grant1b", int'(n < 20), 1);
    repeat (5) step();
    start_val[10 +: 5] = 5'h1F; req[2] = 1'b1;
    repeat (3) step();
    req[1] = 1'b0;
    step();
`ifdef COUNTER_SCHED_ABORT_EN
    chk("abort_clear", int'({grant, done}), 0);
`else
    chk("no_abort_hold", int'(grant), 2);
`endif
    drain("tmo_drain_abort");

    mask = 4'hF; prob = 20; oneshot = 1'b0; rand_start = 1'b1;
    repeat (3000) step();
    mask = 4'h0; rand_start = 1'b0;
    drain("tmo_drain_rand");
    repeat (3) step();
    chk("leftover_events", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
